// File: rtl/ncl_gate_seq.sv
// Exhaustive sweep tester for a weighted NCL threshold gate with hysteresis.
// Drives all 16 patterns, releases inputs one by one and counts mismatches.
module ncl_gate_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] wa,
    input  logic [1:0] wb,
    input  logic [1:0] wc,
    input  logic [1:0] wd,
    input  logic [3:0] thresh,
    input  logic [3:0] settle,
    input  logic       gate_y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic [7:0] err_cnt,
    output logic [4:0] fail_vec
);

    typedef enum logic [3:0] {
        S_IDLE, S_DATA, S_DWAIT, S_DCHK, S_REL,
        S_RWAIT, S_RCHK, S_NEXT, S_FIN
    } state_t;

    state_t     r_state, w_next;
    logic [1:0] r_wa, r_wb, r_wc, r_wd;
    logic [3:0] r_th, r_settle, r_cnt, r_p, r_drv;
    logic       r_held, r_sync1, r_ys;
    logic [7:0] r_err;
    logic [4:0] r_fail;

    logic [3:0] w_sum, w_th_eff, w_drv_rel;
    logic       w_exp, w_expv, w_chk, w_miss;

    assign w_sum = {2'b00, r_wa & {2{r_p[0]}}}
                 + {2'b00, r_wb & {2{r_p[1]}}}
                 + {2'b00, r_wc & {2{r_p[2]}}}
                 + {2'b00, r_wd & {2{r_p[3]}}};
    assign w_th_eff  = (r_th == 4'd0) ? 4'd1 : r_th;
    assign w_exp     = (w_sum >= w_th_eff);
    assign w_drv_rel = r_drv & (r_drv - 4'd1);

    // during release the gate must hold its output until every input is low
    assign w_chk  = (r_state == S_DCHK) || (r_state == S_RCHK);
    assign w_expv = (r_state == S_DCHK) ? w_exp
                  : ((r_drv != 4'd0) ? r_held : 1'b0);
    assign w_miss = w_chk && (r_ys != w_expv);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DATA;
            S_DATA:  w_next = S_DWAIT;
            S_DWAIT: if (r_cnt <= 4'd1) w_next = S_DCHK;
            S_DCHK:  w_next = (r_p != 4'd0) ? S_REL : S_NEXT;
            S_REL:   w_next = S_RWAIT;
            S_RWAIT: if (r_cnt <= 4'd1) w_next = S_RCHK;
            S_RCHK:  w_next = (r_drv != 4'd0) ? S_REL : S_NEXT;
            S_NEXT:  w_next = (r_p == 4'd15) ? S_FIN : S_DATA;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wa     <= 2'd0;
            r_wb     <= 2'd0;
            r_wc     <= 2'd0;
            r_wd     <= 2'd0;
            r_th     <= 4'd0;
            r_settle <= 4'd1;
            r_cnt    <= 4'd0;
            r_p      <= 4'd0;
            r_drv    <= 4'd0;
            r_held   <= 1'b0;
            r_sync1  <= 1'b0;
            r_ys     <= 1'b0;
            r_err    <= 8'd0;
            r_fail   <= 5'd0;
        end else begin
            r_sync1 <= gate_y;
            r_ys    <= r_sync1;
            case (r_state)
                S_IDLE: if (start) begin
                    r_wa     <= wa;
                    r_wb     <= wb;
                    r_wc     <= wc;
                    r_wd     <= wd;
                    r_th     <= thresh;
                    r_settle <= (settle == 4'd0) ? 4'd1 : settle;
                    r_err    <= 8'd0;
                    r_fail   <= 5'd0;
                    r_p      <= 4'd0;
                    r_drv    <= 4'd0;
                end
                S_DATA: begin
                    r_drv <= r_p;
                    r_cnt <= r_settle;
                end
                S_DWAIT, S_RWAIT: r_cnt <= r_cnt - 4'd1;
                S_DCHK: r_held <= w_exp;
                S_REL: begin
                    r_drv <= w_drv_rel;
                    r_cnt <= r_settle;
                end
                S_NEXT: if (r_p != 4'd15) r_p <= r_p + 4'd1;
                S_FIN:  r_drv <= 4'd0;
                default: ;
            endcase
            if (w_miss) begin
                if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                if (!r_fail[4]) r_fail <= {1'b1, r_p};
            end
        end
    end

    assign {d, c, b, a} = r_drv;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_FIN);
    assign err_cnt      = r_err;
    assign fail_vec     = r_fail;

endmodule
